spi_rdid_slave: RTL and testbench
=================================

// Module: spi_rdid_slave
// PURPOSE
//   Synthesizable SPI flash responder on the spi_master bus (SPICLK/SPIMOSI/SPIMISO).
//   Oversamples the bus on clk, decodes the command byte and answers READ ID (0x9F)
//   with a 3-byte JEDEC ID. Serves as the on-chip bus partner for spi_master bring-up.
//   There is no chip-select; frames are delimited by SPICLK idle time.
// PARAMETERS
//   JEDEC_ID     24'h202015  ID returned MSB first (manufacturer, type, capacity)
//   IDLE_CYCLES  16          clk cycles with no SPICLK edge that end a frame (>= 4)
// PORTS
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high reset
//   SPICLK     in   1   SPI clock from master, mode 0, f <= clk/8, low when idle
//   SPIMOSI    in   1   master-out data, sampled on SPICLK rising edge
//   SPIMISO    out  1   slave-out data, updated after SPICLK falling edge
//   cmd_valid  out  1   1-clk pulse when 8th command bit is captured
//   cmd_byte   out  8   last captured command byte, held until next capture
//   busy       out  1   high from first SPICLK rising edge until frame end
//   status_in  in   8   status byte for RDSR (present only with SPI_RDSR_EN)
// BEHAVIOUR
//   Reset: SPIMISO=0, cmd_valid=0, cmd_byte=0, busy=0, state=S_CMD, counters=0.
//   SPICLK and SPIMOSI pass through 2-FF synchronizers; edges are detected on the
//   synchronized SPICLK. Rise/fall actions occur 3 clk after the pin edge.
//   Bit counter: 5 bits. Idle counter: saturating, cleared on any SPICLK edge.
//   S_CMD: on each rise, shift synced MOSI into shift reg (MSB first), count++.
//     On 8th rise: cmd_byte<=shift, cmd_valid=1 for 1 clk, count<=0;
//     0x9F -> S_ID; any other byte -> S_IGNORE.
//   S_ID: on each fall, SPIMISO<=JEDEC_ID[23-count], count++. First ID bit (bit 23)
//     is driven on the fall after the 8th command rise, so it is valid at rise 9.
//     After bit 0 (count=23), wrap to bit 23 (count<=0): ID repeats while clocked.
//   S_IGNORE: SPIMISO held 0; all edges ignored except for idle tracking.
//   Frame end: idle counter reaches IDLE_CYCLES with synced SPICLK low ->
//     state<=S_CMD, count<=0, SPIMISO<=0, busy<=0. Partial command bits discarded;
//     no cmd_valid for a truncated command.
//   Simultaneous edge and timeout in one clk: edge wins, counter clears.
//   Reset mid-frame: returns to reset state immediately; remaining SPICLK edges of
//     the interrupted frame are treated as a new command until the next idle gap.
//   busy rises on the first rise of a frame (same clk as first shift).
// CONFIGURATION
//   SPI_RDSR_EN defined: adds status_in port and state S_SR; command 0x05 -> S_SR,
//     which shifts status_in MSB first on falls (sampled at the 8th command rise),
//     repeating the byte every 8 bits until frame end.
//   SPI_RDSR_EN undefined: no status_in port; 0x05 behaves as any unknown command.
// STRUCTURE
//   Package spi_flash_pkg: CMD_RDID=8'h9F, CMD_RDSR=8'h05, state encodings
//     S_CMD/S_ID/S_IGNORE/S_SR (2-bit localparams), shared with spi_master.
//   Sub-module spi_edge_sync: 2-FF synchronizer plus rise/fall pulse outputs;
//     instantiated once for SPICLK (SPIMOSI uses its sync stage only).
// TESTING
//   1 RDID: SPICLK=clk/8, send 0x9F then 24 clocks -> cmd_valid once, cmd_byte=9F,
//     MISO bytes 0x20,0x20,0x15; busy high throughout, low IDLE_CYCLES after end.
//   2 Wrap: 0x9F then 32 clocks -> bytes 0x20,0x20,0x15,0x20.
//   3 Unknown: send 0x03 + 16 clocks -> cmd_byte=03, SPIMISO constantly 0.
//   4 Truncation: 5 bits then idle 20 clk, then 0x9F -> no pulse after the 5 bits,
//     cmd_byte=9F, correct ID follows.
//   5 Reset mid-ID after 10 ID bits, idle gap, 0x9F -> all outputs 0 during reset,
//     full ID 0x202015 returned afterwards.
//   6 SPI_RDSR_EN, status_in=0xA5: send 0x05 + 16 clocks -> MISO 0xA5,0xA5;
//     without the macro the same stimulus gives MISO=0.

Source files
------------

// File: rtl/spi_flash_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_pkg
// Description : Shared SPI flash command codes and responder state encodings,
//               common to spi_rdid_slave and spi_master.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_flash_pkg;

  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [1:0] {
    S_CMD    = 2'd0,
    S_ID     = 2'd1,
    S_IGNORE = 2'd2,
    S_SR     = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_edge_sync
// Description : 2-FF synchronizer for an asynchronous input plus single-clk
//               rise/fall pulses derived from the synchronized level.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next-state for the synchronizer chain and the edge-history flop
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchronizer and history registers
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_rdid_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_rdid_slave
// Description : Oversampled SPI flash responder (mode 0, no chip-select).
//               Decodes the command byte and answers READ ID (0x9F) with a
//               repeating 3-byte JEDEC ID. Frames end after IDLE_CYCLES clk
//               without SPICLK activity.
//               Optional macro SPI_RDSR_EN adds status_in and the RDSR (0x05)
//               command, which returns status_in repeatedly.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rdid_slave
  import spi_flash_pkg::*;
#(
  parameter logic [23:0] JEDEC_ID    = 24'h202015,
  parameter int          IDLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SPICLK,
  input  logic       SPIMOSI,
`ifdef SPI_RDSR_EN
  input  logic [7:0] status_in,
`endif
  output logic       SPIMISO,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       busy
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);

  logic          sclk_s, sclk_rise, sclk_fall;
  logic          mosi_meta_q, mosi_s_q;
  logic          timeout;

  state_t        state_q, state_d;
  logic [4:0]    count_q, count_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    cmd_byte_q, cmd_byte_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          miso_q, miso_d;
  logic          busy_q, busy_d;
  logic [IW-1:0] idle_q, idle_d;
`ifdef SPI_RDSR_EN
  logic [7:0]    status_q, status_d;
`endif

  spi_edge_sync u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .d     (SPICLK),
    .q     (sclk_s),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // MOSI gets the same two-stage delay as SPICLK so it lines up with the rise pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      mosi_meta_q <= SPIMOSI;
      mosi_s_q    <= mosi_meta_q;
    end
  end

  // An SPICLK edge in the same clk always beats the idle timeout
  assign timeout = (idle_q == IW'(IDLE_CYCLES)) && !sclk_s && !(sclk_rise || sclk_fall);

  // Command decode, response shifting, idle tracking and frame-end handling
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    miso_d      = miso_q;
    busy_d      = busy_q;
    idle_d      = idle_q;
`ifdef SPI_RDSR_EN
    status_d    = status_q;
`endif

    if (sclk_rise || sclk_fall) begin
      idle_d = '0;
    end else if (idle_q != IW'(IDLE_CYCLES)) begin
      idle_d = idle_q + IW'(1);
    end

    if (sclk_rise) begin
      busy_d = 1'b1;
    end

    case (state_q)
      S_CMD: begin
        if (sclk_rise) begin
          shift_d = {shift_q[6:0], mosi_s_q};
          if (count_q == 5'd7) begin
            cmd_byte_d  = shift_d;
            cmd_valid_d = 1'b1;
            count_d     = 5'd0;
            if (shift_d == CMD_RDID) begin
              state_d = S_ID;
`ifdef SPI_RDSR_EN
            end else if (shift_d == CMD_RDSR) begin
              state_d  = S_SR;
              status_d = status_in;
`endif
            end else begin
              state_d = S_IGNORE;
            end
          end else begin
            count_d = count_q + 5'd1;
          end
        end
      end
      S_ID: begin
        if (sclk_fall) begin
          miso_d  = JEDEC_ID[5'd23 - count_q];
          count_d = (count_q == 5'd23) ? 5'd0 : count_q + 5'd1;
        end
      end
`ifdef SPI_RDSR_EN
      S_SR: begin
        if (sclk_fall) begin
          miso_d  = status_q[3'd7 - count_q[2:0]];
          count_d = (count_q == 5'd7) ? 5'd0 : count_q + 5'd1;
        end
      end
`endif
      default: begin
        miso_d = 1'b0;
      end
    endcase

    if (timeout) begin
      state_d = S_CMD;
      count_d = 5'd0;
      miso_d  = 1'b0;
      busy_d  = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CMD;
      count_q     <= 5'd0;
      shift_q     <= 8'd0;
      cmd_byte_q  <= 8'd0;
      cmd_valid_q <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      idle_q      <= '0;
`ifdef SPI_RDSR_EN
      status_q    <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      idle_q      <= idle_d;
`ifdef SPI_RDSR_EN
      status_q    <= status_d;
`endif
    end
  end

  assign SPIMISO   = miso_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_rdid_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_rdid_slave
// Description : Self-checking bench for spi_rdid_slave. Frame vectors come
//               from a table; truncation and mid-frame reset are hand-written.
//               Honours SPI_RDSR_EN for the RDSR vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_rdid_slave;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       SPICLK = 1'b0;
  logic       SPIMOSI = 1'b0;
  logic [7:0] status_in = 8'hA5;
  logic       SPIMISO;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  bit miso_seen = 1'b0;

`ifdef SPI_RDSR_EN
  localparam bit RDSR = 1'b1;
`else
  localparam bit RDSR = 1'b0;
`endif

  spi_rdid_slave dut (
    .clk       (clk),
    .reset     (reset),
    .SPICLK    (SPICLK),
    .SPIMOSI   (SPIMOSI),
`ifdef SPI_RDSR_EN
    .status_in (status_in),
`endif
    .SPIMISO   (SPIMISO),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Observers sample away from the active edge
  always @(negedge clk) begin
    if (cmd_valid) pulses++;
    if (SPIMISO) miso_seen = 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One mode-0 bit at clk/8: 4 clk low (MISO sampled at the end), 4 clk high
  task automatic xfer_bit(input logic tx, output logic rx);
    SPIMOSI = tx;
    wait_clk(4);
    rx = SPIMISO;
    SPICLK = 1'b1;
    wait_clk(4);
    SPICLK = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    int          nbytes;
    logic [31:0] exp_miso;  // left-aligned, first byte in [31:24]
    bit          quiet;     // MISO must stay 0 for the whole frame
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [7:0] rx;
    logic       b;
    int         p0;

    vecs[0] = '{"rdid",    8'h9F, 3, 32'h2020_1500, 1'b0};
    vecs[1] = '{"wrap",    8'h9F, 4, 32'h2020_1520, 1'b0};
    vecs[2] = '{"unknown", 8'h03, 2, 32'h0000_0000, 1'b1};
    vecs[3] = '{"rdsr",    8'h05, 2, RDSR ? 32'hA5A5_0000 : 32'h0, !RDSR};

    wait_clk(3);
    check("reset_miso", {31'd0, SPIMISO}, 32'd0);
    check("reset_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("reset_cmd_byte", {24'd0, cmd_byte}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    wait_clk(5);

    for (int v = 0; v < 4; v++) begin
      p0 = pulses;
      miso_seen = 1'b0;
      xfer_byte(vecs[v].cmd, rx);
      for (int k = 0; k < vecs[v].nbytes; k++) begin
        xfer_byte(8'h00, rx);
        check($sformatf("%s_byte%0d", vecs[v].name, k), {24'd0, rx},
              {24'd0, vecs[v].exp_miso[31 - 8*k -: 8]});
      end
      check($sformatf("%s_cmd_byte", vecs[v].name), {24'd0, cmd_byte}, {24'd0, vecs[v].cmd});
      check($sformatf("%s_pulses", vecs[v].name), pulses - p0, 32'd1);
      check($sformatf("%s_busy_end", vecs[v].name), {31'd0, busy}, 32'd1);
      wait_clk(10);
      check($sformatf("%s_busy_hold", vecs[v].name), {31'd0, busy}, 32'd1);
      wait_clk(15);
      check($sformatf("%s_busy_idle", vecs[v].name), {31'd0, busy}, 32'd0);
      if (vecs[v].quiet)
        check($sformatf("%s_miso_quiet", vecs[v].name), {31'd0, miso_seen}, 32'd0);
      wait_clk(5);
    end

    // Truncated command: 5 bits then idle, no pulse, then a clean RDID
    p0 = pulses;
    for (int i = 0; i < 5; i++) xfer_bit(1'b1, b);
    wait_clk(20);
    check("trunc_no_pulse", pulses - p0, 32'd0);
    check("trunc_busy_low", {31'd0, busy}, 32'd0);
    xfer_byte(8'h9F, rx);
    check("trunc_pulse", pulses - p0, 32'd1);
    check("trunc_cmd_byte", {24'd0, cmd_byte}, 32'h9F);
    for (int k = 0; k < 3; k++) begin
      xfer_byte(8'h00, rx);
      check($sformatf("trunc_id%0d", k), {24'd0, rx}, {24'd0, vecs[0].exp_miso[31 - 8*k -: 8]});
    end
    wait_clk(30);

    // Reset after 10 ID bits, leftover clocks, idle gap, then full RDID
    xfer_byte(8'h9F, rx);
    xfer_byte(8'h00, rx);
    xfer_bit(1'b0, b);
    xfer_bit(1'b0, b);
    reset = 1'b1;
    wait_clk(2);
    check("rst_miso", {31'd0, SPIMISO}, 32'd0);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_cmd_byte", {24'd0, cmd_byte}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    wait_clk(2);
    for (int i = 0; i < 3; i++) xfer_bit(1'b1, b);
    check("rst_leftover_busy", {31'd0, busy}, 32'd1);
    wait_clk(30);
    p0 = pulses;
    xfer_byte(8'h9F, rx);
    check("rst_cmd_byte_after", {24'd0, cmd_byte}, 32'h9F);
    check("rst_pulse_after", pulses - p0, 32'd1);
    for (int k = 0; k < 3; k++) begin
      xfer_byte(8'h00, rx);
      check($sformatf("rst_id%0d", k), {24'd0, rx}, {24'd0, vecs[0].exp_miso[31 - 8*k -: 8]});
    end
    wait_clk(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
